// File: rtl/tile_reader_pkg.sv
// Shared definitions for the tile datapath: FSM state encoding, address and
// channel-index widths, and the tile pixel-count helper.
package tile_reader_pkg;

    localparam int ADDR_W = 8;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Pixels per tile; one bit wider than an address so a full 256-pixel
    // tile is representable.
    function automatic logic [ADDR_W:0] tile_pixels(input logic [ADDR_W-1:0] w,
                                                    input logic [ADDR_W-1:0] h);
        return {1'b0, w} * {1'b0, h};
    endfunction

endpackage

// File: rtl/tile_reader_if.sv
// AXI-Stream pixel link between the tile reader and the compression pipeline.
interface tile_reader_if
    import tile_reader_pkg::*;
#(
    parameter int width = 8
) ();
    logic [width-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic [CH_W-1:0]  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/tile_reader_fifo.sv
// Output buffer for read beats. Entries carry {data, last, channel}. There is
// no write-to-read bypass, so the head only ever comes from stored entries.
module tile_reader_fifo
    import tile_reader_pkg::*;
#(
    parameter  int width = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             wr_last,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             rd_last,
    output logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [width-1:0] data_mem_r [DEPTH];
    logic             last_mem_r [DEPTH];
    logic [CH_W-1:0]  ch_mem_r   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    assign wr_ok_s = wr_en && (count_r != FULL_CNT);
    assign rd_ok_s = rd_en && (count_r != CNT_W'(0));

    // Storage, pointers and occupancy; reset flushes every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_r[i] <= width'(0);
                last_mem_r[i] <= 1'b0;
                ch_mem_r[i]   <= CH_W'(0);
            end
        end else begin
            if (wr_ok_s) begin
                data_mem_r[wr_ptr_r] <= wr_data;
                last_mem_r[wr_ptr_r] <= wr_last;
                ch_mem_r[wr_ptr_r]   <= wr_ch;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = data_mem_r[rd_ptr_r];
    assign rd_last = last_mem_r[rd_ptr_r];
    assign rd_ch   = ch_mem_r[rd_ptr_r];
    assign count   = count_r;

endmodule

// File: rtl/tile_reader.sv
// Reads a stored tile plane by plane from the tile RAM and streams it out as
// AXI-Stream pixels. Reads are only issued while the output buffer has room
// for every read already in flight, so backpressure never loses data.
module tile_reader
    import tile_reader_pkg::*;
#(
    parameter int width      = 8,
    parameter int CHANNELS   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] tile_width,
    input  logic [ADDR_W-1:0] tile_height,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rvalid,
    output logic [ADDR_W-1:0] raddr,
    output logic [CH_W-1:0]   rchannel,
    input  logic [width-1:0]  rdata,
    tile_reader_if.master     m_axis
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    state_e            state_r, state_nxt_s;
    logic [ADDR_W:0]   n_r, n_s;
    logic [ADDR_W-1:0] addr_cnt_r, addr_s;
    logic [CH_W-1:0]   ch_cnt_r, ch_s;
    logic              last_addr_s, final_read_s, zero_dim_s, issue_s;
    logic [CNT_W:0]    occupancy_s;
    logic              busy_r, done_r, rvalid_r, rlast_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [CH_W-1:0]   rchannel_r;
    logic              dly_valid_r, dly_last_r;
    logic [CH_W-1:0]   dly_ch_r;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [width-1:0]  head_data_s;
    logic              head_last_s;
    logic [CH_W-1:0]   head_ch_s;
    logic              tvalid_s, pop_s;

    // Select the next read position: the start of a new tile while idle,
    // otherwise the running counters.
    always_comb begin
        n_s    = n_r;
        addr_s = addr_cnt_r;
        ch_s   = ch_cnt_r;
        if (state_r == ST_IDLE) begin
            n_s    = tile_pixels(tile_width, tile_height);
            addr_s = ADDR_W'(0);
            ch_s   = CH_W'(0);
        end else begin
            n_s    = n_r;
            addr_s = addr_cnt_r;
            ch_s   = ch_cnt_r;
        end
        last_addr_s  = ({1'b0, addr_s} == (n_s - (ADDR_W + 1)'(1)));
        final_read_s = last_addr_s && (ch_s == LAST_CH);
        zero_dim_s   = (tile_width == ADDR_W'(0)) || (tile_height == ADDR_W'(0));
        // Buffered beats plus reads not yet written; this cycle's pop is not counted.
        occupancy_s  = {1'b0, fifo_count_s} + (CNT_W + 1)'(rvalid_r) + (CNT_W + 1)'(dly_valid_r);
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (zero_dim_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        issue_s     = 1'b1;
                        state_nxt_s = final_read_s ? ST_DRAIN : ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (occupancy_s < CREDITS) begin
                    issue_s     = 1'b1;
                    state_nxt_s = final_read_s ? ST_DRAIN : ST_RUN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((fifo_count_s == CNT_W'(0)) && !rvalid_r && !dly_valid_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Read port, counters, status flags and the one-cycle tag delay that
    // lines each read's tag up with its returning rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_r         <= (ADDR_W + 1)'(0);
            addr_cnt_r  <= ADDR_W'(0);
            ch_cnt_r    <= CH_W'(0);
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rvalid_r    <= 1'b0;
            raddr_r     <= ADDR_W'(0);
            rchannel_r  <= CH_W'(0);
            rlast_r     <= 1'b0;
            dly_valid_r <= 1'b0;
            dly_last_r  <= 1'b0;
            dly_ch_r    <= CH_W'(0);
        end else begin
            busy_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r   <= (state_nxt_s == ST_DONE);
            rvalid_r <= issue_s;
            if ((state_r == ST_IDLE) && start) begin
                n_r <= n_s;
            end
            if (issue_s) begin
                raddr_r    <= addr_s;
                rchannel_r <= ch_s;
                rlast_r    <= last_addr_s;
                if (last_addr_s) begin
                    addr_cnt_r <= ADDR_W'(0);
                    ch_cnt_r   <= ch_s + CH_W'(1);
                end else begin
                    addr_cnt_r <= addr_s + ADDR_W'(1);
                    ch_cnt_r   <= ch_s;
                end
            end
            dly_valid_r <= rvalid_r;
            dly_last_r  <= rlast_r;
            dly_ch_r    <= rchannel_r;
        end
    end

    tile_reader_fifo #(
        .width (width),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dly_valid_r),
        .wr_data (rdata),
        .wr_last (dly_last_r),
        .wr_ch   (dly_ch_r),
        .rd_en   (pop_s),
        .rd_data (head_data_s),
        .rd_last (head_last_s),
        .rd_ch   (head_ch_s),
        .count   (fifo_count_s)
    );

    assign tvalid_s = (fifo_count_s != CNT_W'(0));
    assign pop_s    = tvalid_s && m_axis.tready;

    assign m_axis.tdata  = head_data_s;
    assign m_axis.tvalid = tvalid_s;
    assign m_axis.tlast  = head_last_s;
    assign m_axis.tuser  = head_ch_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign rvalid   = rvalid_r;
    assign raddr    = raddr_r;
    assign rchannel = rchannel_r;

endmodule

// File: tb/tb_tile_reader.sv
// Self-checking bench for tile_reader: a RAM model with one-cycle read
// latency, randomized tile contents and tready, and a reference beat queue
// built directly from the channel-major readout order.
module tb_tile_reader;
    import tile_reader_pkg::*;

    localparam int CH    = 4;
    localparam int DEPTH = 4;

    logic       clk, rst, start, busy, done, rvalid;
    logic [7:0] tile_width, tile_height, raddr, rdata;
    logic [1:0] rchannel;

    tile_reader_if #(.width(8)) axis ();

    tile_reader #(.width(8), .CHANNELS(CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tile_width(tile_width), .tile_height(tile_height),
        .start(start), .busy(busy), .done(done), .rvalid(rvalid), .raddr(raddr),
        .rchannel(rchannel), .rdata(rdata), .m_axis(axis)
    );

    typedef struct packed { logic [7:0] d; logic l; logic [1:0] c; } beat_t;

    beat_t      expq[$];
    logic [7:0] ram [CH][256];
    int n_cmp = 0, n_err = 0, cyc = 0;
    int n_cur = 0, exp_rd_idx = 0, rv_pulses = 0, beats = 0, issued = 0, popped = 0;
    int done_cyc = 0, first_rv_cyc = 0, first_tv_cyc = 0, s_cyc = 0;
    int rmode = 0, stall_end = 0;
    bit done_seen = 0, first_rv_seen = 0, first_tv_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // RAM model: data for a read seen in one cycle is presented in the next.
    initial begin
        logic       pv;
        logic [7:0] pa;
        logic [1:0] pc;
        pv = 1'b0; pa = 8'd0; pc = 2'd0; rdata = 8'd0;
        forever begin
            @(negedge clk);
            rdata = pv ? ram[pc][pa] : 8'($urandom);
            pv = rvalid; pa = raddr; pc = rchannel;
        end
    end

    // Downstream ready pattern.
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                1:       axis.tready = 1'($urandom_range(0, 1));
                2:       axis.tready = (cyc >= stall_end);
                default: axis.tready = 1'b1;
            endcase
        end
    end

    // Monitor: read order, credit bound, stall stability and beat contents.
    initial begin
        beat_t      e;
        bit         prev_stall;
        logic [7:0] prev_d;
        logic       prev_l;
        logic [1:0] prev_u;
        prev_stall = 0; prev_d = 8'd0; prev_l = 1'b0; prev_u = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                issued = 0; popped = 0; prev_stall = 0;
            end else begin
                if (rvalid) begin
                    rv_pulses++; issued++;
                    if (!first_rv_seen) begin first_rv_seen = 1; first_rv_cyc = cyc; end
                    if (n_cur == 0) chk("read_on_empty_tile", 1, 0);
                    else begin
                        chk("raddr", raddr, exp_rd_idx % n_cur);
                        chk("rchannel", rchannel, exp_rd_idx / n_cur);
                    end
                    exp_rd_idx++;
                end
                chk("outstanding_le_depth", ((issued - popped) <= DEPTH), 1);
                if (prev_stall) begin
                    chk("stall_tvalid", axis.tvalid, 1);
                    chk("stall_tdata", axis.tdata, prev_d);
                    chk("stall_tlast", axis.tlast, prev_l);
                    chk("stall_tuser", axis.tuser, prev_u);
                end
                if (axis.tvalid && !first_tv_seen) begin first_tv_seen = 1; first_tv_cyc = cyc; end
                if (axis.tvalid && axis.tready) begin
                    if (expq.size() == 0) chk("unexpected_beat", 1, 0);
                    else begin
                        e = expq.pop_front();
                        chk("tdata", axis.tdata, e.d);
                        chk("tlast", axis.tlast, e.l);
                        chk("tuser", axis.tuser, e.c);
                    end
                    beats++; popped++;
                end
                prev_stall = axis.tvalid && !axis.tready;
                prev_d = axis.tdata; prev_l = axis.tlast; prev_u = axis.tuser;
                if (done) begin done_seen = 1; done_cyc = cyc; end
            end
        end
    end

    task automatic chk_reset();
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_rvalid", rvalid, 0);     chk("rst_raddr", raddr, 0);
        chk("rst_rchannel", rchannel, 0); chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tlast", axis.tlast, 0);  chk("rst_tuser", axis.tuser, 0);
        chk("rst_tdata", axis.tdata, 0);
    endtask

    task automatic begin_tile(input int w, input int h, input int mode, input int stall);
        n_cur = w * h;
        expq.delete();
        for (int c = 0; c < CH; c++) begin
            for (int a = 0; a < n_cur; a++) begin
                ram[c][a] = 8'($urandom);
                expq.push_back('{d: ram[c][a], l: (a == n_cur - 1), c: 2'(c)});
            end
        end
        exp_rd_idx = 0; rv_pulses = 0; beats = 0;
        done_seen = 0; first_rv_seen = 0; first_tv_seen = 0;
        rmode = mode;
        stall_end = cyc + 1 + stall;
        @(posedge clk);
        #2;
        s_cyc = cyc;
        tile_width = 8'(w); tile_height = 8'(h); start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic finish_tile(input int exp_off, input bit dup, input bit stall_chk, input bit lat_chk);
        int budget;
        budget = 8 * CH * n_cur + 100;
        while (!done_seen && budget > 0) begin
            @(posedge clk);
            #2;
            if (dup && (cyc == s_cyc + 5 || cyc == s_cyc + 30)) begin
                tile_width = 8'd1; tile_height = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (stall_chk && cyc == s_cyc + 20) begin
                chk("stall_read_count", rv_pulses, DEPTH);
                chk("stall_rvalid_low", rvalid, 0);
            end
            budget--;
        end
        start = 1'b0;
        chk("done_seen", done_seen, 1);
        if (exp_off >= 0) chk("done_cycle", done_cyc - s_cyc, exp_off);
        if (lat_chk) begin
            chk("first_read_latency", first_rv_cyc - s_cyc, 1);
            chk("first_beat_latency", first_tv_cyc - s_cyc, 3);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("beat_count", beats, CH * n_cur);
        chk("read_count", rv_pulses, CH * n_cur);
        chk("model_drained", expq.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tile_width = 8'd0; tile_height = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;

        // 4x4, full throughput: done 4*16+4 cycles after start.
        begin_tile(4, 4, 0, 0);
        finish_tile(68, 0, 0, 1);

        // 16x16 with random ready.
        begin_tile(16, 16, 1, 0);
        finish_tile(-1, 0, 0, 0);

        // Ready held low for 20 cycles.
        begin_tile(4, 4, 2, 20);
        finish_tile(-1, 0, 1, 0);

        // Zero width: done one cycle after start, nothing read or sent.
        begin_tile(0, 5, 0, 0);
        finish_tile(1, 0, 0, 0);

        // Extra start pulses while busy change nothing.
        begin_tile(4, 4, 0, 0);
        finish_tile(68, 1, 0, 1);

        // Abort mid-plane, then a fresh 2x3 tile.
        begin_tile(16, 16, 0, 0);
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset();
        chk("no_done_on_abort", done_seen, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        begin_tile(2, 3, 0, 0);
        finish_tile(28, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tile_reader.md
# tile_reader

Reads a stored tile back out of the tile RAM read port, one channel plane at a time, and transmits it as an AXI-Stream pixel stream. It is the read-side counterpart of the tile receive path: the receive path fills the RAM with packed 4-channel words, and this block drives the RAM's `rvalid`/`raddr`/`rchannel` port, captures `rdata` one cycle later, and absorbs downstream backpressure. It sits between the tile RAM and the per-channel compression pipeline.

## Interface
- `width`, default 8: pixel width in bits, which is also the width of `rdata` and `m_axis_tdata`.
- `CHANNELS`, default 4: number of channel planes emitted per tile, in order 0..CHANNELS-1. Legal range is 1..4.
- `FIFO_DEPTH`, default 4: depth of the output buffer, in entries.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `tile_width`  in  8  pixels per row. Sampled on `start`.
- `tile_height`  in  8  rows per tile. Sampled on `start`. The product `tile_width*tile_height` must be ≤256.
- `start`  in  1  one-cycle pulse that begins a readout. Ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is asserted.
- `done`  out  1  one-cycle pulse after the last beat has been accepted downstream.
- `rvalid`  out  1  RAM read enable.
- `raddr`  out  8  RAM word address.
- `rchannel`  out  2  channel select presented to the RAM with each read.
- `rdata`  in  width  RAM read data. Valid on the cycle after `rvalid`.
- `m_axis_tdata`  out  width  pixel.
- `m_axis_tvalid`  out  1  AXI-Stream valid.
- `m_axis_tready`  in  1  AXI-Stream ready.
- `m_axis_tlast`  out  1  marks the last pixel of each channel plane.
- `m_axis_tuser`  out  2  channel index of the current beat.

## Operation
- **Reset values:** `busy`=0, `done`=0, `rvalid`=0, `raddr`=0, `rchannel`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0. The FIFO and all counters are cleared.
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on `start`. At that edge the block latches `N = tile_width*tile_height` (9-bit), zeroes the address counter and the channel counter.
  - IDLE→DONE on `start` if either dimension is 0. No reads are issued and no beats are emitted.
  - RUN→DRAIN when the read for address N-1 of channel CHANNELS-1 is issued.
  - DRAIN→DONE when the FIFO is empty and no read is in flight.
  - DONE→IDLE unconditionally after one cycle.
- **Read issue (RUN state):** a read is issued when `fifo_count + inflight < FIFO_DEPTH`. `inflight` counts issued reads whose data has not yet been written into the FIFO. The pop in the current cycle is not credited.
- **Issue order:** channel-major. For each channel c = 0..CHANNELS-1, addresses 0..N-1 are issued in order. The address counter wraps to 0 and the channel counter increments after N-1.
- **Tags:** each FIFO entry holds {data, last, channel}. `last` = (address == N-1). The tag is carried with the read through a 1-cycle delay stage.
- **Output:** `m_axis_*` present the FIFO head. A pop occurs when `m_axis_tvalid && m_axis_tready`. Once asserted, `tdata`, `tlast` and `tuser` are held stable until the beat is accepted.
- **Overflow:** the FIFO never overflows, by construction of the credit rule. An assertion in the bench checks this.
- **Reset during operation:** `rst` aborts immediately. The FSM returns to IDLE, the FIFO and in-flight tracking are flushed, and `done` is not pulsed.
- **`start` while not IDLE:** ignored and has no effect.

## Timing
- **Read address:** `start` accepted at cycle 0 → `rvalid`=1 with `raddr`=0, `rchannel`=0 at cycle 1.
- **Read data:** `rdata` is captured at the end of cycle 2 and appears as `m_axis_tvalid`=1 at cycle 3. First-beat latency is 3 cycles.
- **Throughput:** with `m_axis_tready` held at 1, sustained rate is 1 beat/cycle with no bubbles between channel planes. A full readout completes in `CHANNELS*N` + 3 cycles, followed by `done` on the next cycle.
- **Backpressure:** with `m_axis_tready`=0, at most FIFO_DEPTH reads are outstanding. `rvalid` stays low until credit frees. There is no combinational path from `m_axis_tready` to `rvalid`.
- **Outputs:** `rvalid`, `raddr`, `rchannel`, `busy`, `done` and all `m_axis_*` signals are registered.

## Structure
- **Shared package:** holds the FSM state enum (IDLE/RUN/DRAIN/DONE), the 8-bit address/dimension width constant, and the 2-bit channel-index width. The tile receive path uses the same width constants.
- **Sub-module:** `tile_reader_fifo`, a synchronous FIFO of depth FIFO_DEPTH holding {data, last, channel}, with a `count` output. It has no bypass, so the head is always a registered output.

## Test plan
- **4×4 tile, CHANNELS=4, tready=1:** 64 beats, ordered channel 0 addresses 0..15, then channel 1, etc. `tlast` at beats 16, 32, 48 and 64. `tuser` steps 0→3. `done` occurs 68 cycles after `start`.
- **Random tready (50% duty), 16×16 tile:**
  - every beat matches the reference model;
  - no FIFO overflow;
  - `tdata` is stable while stalled;
  - `fifo_count + inflight` never exceeds 4.
- **tready=0 for 20 cycles after `start`:** exactly 4 `rvalid` pulses, then `rvalid` stays low. Releasing tready resumes the sequence with no loss.
- **tile_width=0:** `done` pulses at cycle 1. Zero beats and no `rvalid`.
- **`rst` asserted mid-plane, then a new `start` with a 2×3 tile:** the new stream begins at `raddr`=0, `rchannel`=0 with no stale beats, and emits CHANNELS×6 beats.
- **`start` pulsed while busy:** ignored. Beat count and `done` timing are unchanged from the single-start run.
